// File: rtl/simd_pkg.sv
// Shared definitions for the packed-SIMD saturation datapath:
// width codes, lane count, saturation byte constants and the buffer entry layout.
package simd_pkg;

   localparam logic [1:0] W8  = 2'b00;
   localparam logic [1:0] W16 = 2'b01;
   localparam logic [1:0] W32 = 2'b10;

   localparam int NUM_LANES = 4;
   localparam int BUF_DEPTH = 2;

   localparam logic [7:0] SAT_POS_MSB = 8'h7F;
   localparam logic [7:0] SAT_POS_LO  = 8'hFF;
   localparam logic [7:0] SAT_NEG_MSB = 8'h80;
   localparam logic [7:0] SAT_NEG_LO  = 8'h00;

   // One output-buffer slot: the saturated word plus its sideband.
   typedef struct packed {
      logic [31:0]          data;
      logic [1:0]           width;
      logic [NUM_LANES-1:0] sat;
   } entry_t;

endpackage

// File: rtl/sat_byte_mux.sv
// Per-byte saturation substitute: replaces one byte of the raw sum with the
// signed max/min fragment when saturation is enabled for that byte.
module sat_byte_mux
   import simd_pkg::*;
(
   input  logic [7:0] byte_in,
   input  logic       enable,
   input  logic       sign,
   input  logic       last,
   output logic [7:0] byte_out
);

   // Choose the raw byte or the max/min fragment for this byte position.
   always_comb begin
      // NOTE: assigning a default first means every path writes byte_out, so no latch is inferred.
      byte_out = byte_in;
      if (enable) begin
         if (sign) byte_out = last ? SAT_POS_MSB : SAT_POS_LO;
         else      byte_out = last ? SAT_NEG_MSB : SAT_NEG_LO;
      end
   end

endmodule

// File: rtl/simd_sat_stage.sv
// Saturation substitute stage with a 2-entry valid/ready output buffer and
// sticky per-byte saturation status.
// Optional macro SIMD_SAT_COUNT_EN adds a 16-bit saturating count of
// accepted beats that carried any saturation (sat_count port).
module simd_sat_stage
   import simd_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          sum,
   input  logic [1:0]           width,
   input  logic [NUM_LANES-1:0] sat_enable,
   input  logic [NUM_LANES-1:0] sat_sign,
   input  logic [NUM_LANES-1:0] sat_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          result,
   output logic [1:0]           out_width,
   output logic [NUM_LANES-1:0] out_sat,
   output logic [NUM_LANES-1:0] sticky_sat,
   input  logic                 sticky_clr
`ifdef SIMD_SAT_COUNT_EN
   ,
   output logic [15:0]          sat_count
`endif
);

   logic [31:0] sat_word;
   entry_t      fifo_mem [BUF_DEPTH];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;
   logic        push;
   logic        pop;

   // Byte substitution ahead of the buffer; lane grouping is already encoded
   // in the per-byte vectors, so width plays no part here.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      sat_byte_mux u_mux (
         .byte_in  (sum[8*i +: 8]),
         .enable   (sat_enable[i]),
         .sign     (sat_sign[i]),
         .last     (sat_last[i]),
         .byte_out (sat_word[8*i +: 8])
      );
   end

   // Handshake qualifiers; ready depends only on occupancy, never on out_ready.
   always_comb begin
      in_ready  = (count < 2'd2);
      out_valid = (count != 2'd0);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
   end

   // Buffer storage and pointers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         // NOTE: the two slots are reset because result must read 0 straight out of reset.
         for (int i = 0; i < BUF_DEPTH; i++) fifo_mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= '{data: sat_word, width: width, sat: sat_enable};
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
      end
   end

   // Occupancy count: push and pop together leave it unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Head of the buffer drives the outputs; stale when empty.
   always_comb begin
      result    = fifo_mem[rd_ptr].data;
      out_width = fifo_mem[rd_ptr].width;
      out_sat   = fifo_mem[rd_ptr].sat;
   end

   // Sticky status: a same-cycle accept overrides the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_sat <= '0;
      end else if (push) begin
         sticky_sat <= (sticky_clr ? '0 : sticky_sat) | sat_enable;
      end else if (sticky_clr) begin
         sticky_sat <= '0;
      end
   end

`ifdef SIMD_SAT_COUNT_EN
   logic counted;
   assign counted = push && (|sat_enable);

   // Saturating count of accepted beats that saturated any byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_count <= 16'd0;
      end else if (sticky_clr) begin
         sat_count <= counted ? 16'd1 : 16'd0;
      end else if (counted && (sat_count != 16'hFFFF)) begin
         sat_count <= sat_count + 16'd1;
      end
   end
`endif

endmodule

// File: doc/simd_sat_stage.md
Name: simd_sat_stage

Overview:
- Downstream stage of the packed-SIMD adder control.
- Consumes the raw 32-bit lane sums plus the per-byte sat_enable/sat_sign/sat_last vectors, and substitutes saturated bytes where enabled.
- Registers the result into a 2-entry output buffer with valid/ready handshakes on both sides.
- Keeps sticky per-byte saturation status for software readback.

Parameters:
- LANES, 4, number of byte lanes in the packed word (fixed at 4; other values unsupported).
- DEPTH, 2, output buffer entries (fixed at 2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- sum  in  32  raw packed adder result, byte i = sum[8i+7:8i]
- width  in  2  00 = 4x8-bit, 01 = 2x16-bit, 10 = 1x32-bit, 11 = reserved
- sat_enable  in  4  per-byte substitute enable
- sat_sign  in  4  per-byte saturation direction: 1 = positive max, 0 = negative min
- sat_last  in  4  per-byte flag: this byte is the MSB byte of its element
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  32  saturated packed result
- out_width  out  2  width carried alongside the result
- out_sat  out  4  sat_enable carried alongside the result
- sticky_sat  out  4  OR of sat_enable over all accepted beats since the last clear
- sticky_clr  in  1  synchronous clear of sticky_sat

Behaviour:
- Byte substitution (combinational, ahead of the buffer), when sat_enable[i] = 1:
  - sat_sign[i] = 1: byte = 8'h7F if sat_last[i], else 8'hFF.
  - sat_sign[i] = 0: byte = 8'h80 if sat_last[i], else 8'h00.
  - sat_enable[i] = 0: byte passes sum unchanged.
- No width-based masking: the control stage already encodes lane grouping in these vectors. width = 11 passes through untouched.
- Handshake:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count < 2); it does not depend on out_ready in the same cycle (no combinational ready path).
- Latency: a beat accepted at edge N appears on result/out_valid after edge N (1 cycle) when the buffer was empty. Results leave in FIFO order.
- Buffer: count 0..2, read/write pointers wrap mod 2.
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together: count unchanged, data ordering preserved.
  - Full (count = 2): in_ready = 0, no push.
  - Empty: out_valid = 0; result/out_width/out_sat hold their last value (don't-care).
- sticky_sat:
  - On accept: sticky_sat |= sat_enable.
  - sticky_clr with no accept: cleared to 0.
  - sticky_clr and accept in the same cycle: sticky_sat = sat_enable of the accepted beat (the set wins over the clear).
- Reset (asynchronous, any time, including mid-stream):
  - count = 0, pointers = 0, out_valid = 0, in_ready = 1 from the first cycle after reset deasserts.
  - result = 0, out_width = 0, out_sat = 0, sticky_sat = 0.
  - Beats in flight are discarded.
- Stable data rule: the upstream holds sum, width and the sat_* inputs stable while in_valid && !in_ready.

Optional Feature:
- Macro: SIMD_SAT_COUNT_EN
- Defined:
  - Adds output port sat_count, out, 16 bits.
  - sat_count increments by 1 on every accepted beat with |sat_enable, and saturates at 16'hFFFF (no wrap).
  - sticky_clr also zeroes it; clear plus counted accept in the same cycle loads 1.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package simd_pkg:
  - Width codes W8 = 2'b00, W16 = 2'b01, W32 = 2'b10.
  - NUM_LANES = 4.
  - Saturation byte constants SAT_POS_MSB = 8'h7F, SAT_POS_LO = 8'hFF, SAT_NEG_MSB = 8'h80, SAT_NEG_LO = 8'h00.
- One natural sub-module, sat_byte_mux: combinational, inputs byte/enable/sign/last, output byte. Instantiated 4 times.
- The buffer and sticky logic stay in the top module.

Test Plan:
- 32-bit positive overflow: width = 10, sum = 32'h8000_0001, sat_enable = 1111, sat_sign = 1111, sat_last = 1000 -> result = 32'h7FFF_FFFF one cycle later, sticky_sat = 1111.
- 16-bit mixed: width = 01, sum = 32'h1234_8000, sat_enable = 0011, sat_sign = 0000, sat_last = 1010 -> result = 32'h1234_8000 (low half saturated to 16'h8000), out_sat = 0011.
- 8-bit per lane: width = 00, sum = 32'h11223344, sat_enable = 0101, sat_sign = 0100, sat_last = 1111 -> result = 32'h117F3380.
- Backpressure: out_ready = 0, push 3 beats (A, B, C) -> in_ready drops after B and C is held. Then out_ready = 1 -> A, B, C emerge in order, and there is a cycle with simultaneous push and pop where count stays at 1.
- Sticky clear collision: sticky_sat = 1000, then sticky_clr = 1 with an accepted beat carrying sat_enable = 0001 -> sticky_sat = 0001. With SIMD_SAT_COUNT_EN, sat_count = 1.
- Reset mid-stream: 2 beats buffered, assert rst -> out_valid = 0, result = 0, sticky_sat = 0 immediately. After deassert, in_ready = 1 and the old data never appears.
